// File: rtl/iir_out_fifo_pkg.sv
// Shared constants and types for the IIR output buffer.
// Sample width matches the filter datapath; depth/pointer width are the defaults.
// Also holds the per-cycle FIFO operation encoding used by the occupancy counter.
package iir_out_fifo_pkg;

  localparam int SAMPLE_NB   = 10;
  localparam int FIFO_DEPTH  = 8;
  localparam int FIFO_ADDR_W = 3;

  // One bit per port: {write, read}. Values are fixed so the enum can be
  // built directly from the two enables.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RDWR = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/iir_out_fifo_if.sv
// Handshake bundle between the filter/consumer side and the output FIFO.
// slave: FIFO side (takes din/vin/rdy_in/clr_ovf, drives data and status).
// master: environment side (drives samples, ready and overflow clear).
interface iir_out_fifo_if
  import iir_out_fifo_pkg::*;
#(
  parameter int NB     = SAMPLE_NB,
  parameter int ADDR_W = FIFO_ADDR_W
);

  logic [NB-1:0]   din;
  logic            vin;
  logic            rdy_in;
  logic            clr_ovf;
  logic [NB-1:0]   dout;
  logic            vout;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            ovf;

  modport slave (
    input  din, vin, rdy_in, clr_ovf,
    output dout, vout, full, empty, count, ovf
  );

  modport master (
    output din, vin, rdy_in, clr_ovf,
    input  dout, vout, full, empty, count, ovf
  );

endinterface

// File: rtl/iir_out_fifo_regfile.sv
// Sample storage: DEPTH x NB, one synchronous write port, one async read port.
// Ports: clk, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (combinational read).
// No reset on the array; contents are meaningless until written.
module iir_out_fifo_regfile
  import iir_out_fifo_pkg::*;
#(
  parameter int NB     = SAMPLE_NB,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [NB-1:0]     wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [NB-1:0]     rdata_o
);

  logic [NB-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iir_out_fifo.sv
// Elastic output FIFO behind the IIR filter; sample visible the cycle after its write edge.
// Sink backpressure via rdy_in never stalls the filter: writes into a full FIFO with no read are dropped and flag ovf.
// Ports: clk, rst_n (async active-low), bus (slave modport: din/vin/rdy_in/clr_ovf in; dout/vout/full/empty/count/ovf out).
module iir_out_fifo
  import iir_out_fifo_pkg::*;
#(
  parameter int NB     = SAMPLE_NB,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  iir_out_fifo_if.slave bus
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              ovf_q,    ovf_d;

  logic          full;
  logic          empty;
  logic          rd_en;
  logic          wr_en;
  logic          drop;
  fifo_op_e      op;
  logic [NB-1:0] rdata;

  // Status is decoded only from the registered count, so none of these
  // outputs has a combinational path from vin or rdy_in.
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  assign rd_en = !empty && bus.rdy_in;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = bus.vin && (!full || rd_en);
  assign drop  = bus.vin && full && !rd_en;
  assign op    = fifo_op_e'({wr_en, rd_en});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case (op)
      OP_WR:   count_d = count_q + 1'b1;
      OP_RD:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A drop in the same cycle as a clear wins, so no overflow is ever lost.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  iir_out_fifo_regfile #(
    .NB     (NB),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.din),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // Force zero when empty so stale storage never appears on the bus.
  assign bus.dout  = empty ? '0 : rdata;
  assign bus.vout  = !empty;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_iir_out_fifo.sv
module tb_iir_out_fifo;
  import iir_out_fifo_pkg::*;

  localparam int NB    = SAMPLE_NB;
  localparam int DEPTH = FIFO_DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  iir_out_fifo_if bus ();

  iir_out_fifo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: the stored samples in arrival order, plus the sticky flag.
  logic [NB-1:0] model_q [$];
  logic          model_ovf = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor + scoreboard: checks outputs against the model, then advances the
  // model with the inputs that the next rising edge will see.
  always @(negedge clk) begin
    int            sz;
    logic          rd;
    logic          dropped;
    logic [NB-1:0] head;
    if (!rst_n) begin
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_vout",  32'(bus.vout),  32'd0);
      check("rst_dout",  32'(bus.dout),  32'd0);
      check("rst_ovf",   32'(bus.ovf),   32'd0);
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      sz = model_q.size();
      check("count", 32'(bus.count), 32'(sz));
      check("empty", 32'(bus.empty), 32'(sz == 0));
      check("full",  32'(bus.full),  32'(sz == DEPTH));
      check("vout",  32'(bus.vout),  32'(sz != 0));
      check("ovf",   32'(bus.ovf),   32'(model_ovf));
      rd = (sz != 0) && bus.rdy_in;
      if (rd) begin
        head = model_q.pop_front();
        check("sb_data", 32'(bus.dout), 32'(head));
      end else if (sz != 0) begin
        check("dout_hold", 32'(bus.dout), 32'(model_q[0]));
      end else begin
        check("dout_zero", 32'(bus.dout), 32'd0);
      end
      dropped = 1'b0;
      if (bus.vin) begin
        if (sz < DEPTH || rd) model_q.push_back(bus.din);
        else dropped = 1'b1;
      end
      if (dropped) model_ovf = 1'b1;
      else if (bus.clr_ovf) model_ovf = 1'b0;
    end
  end

  logic [NB-1:0] v1 [3];

  initial begin
    v1 = '{10'd5, 10'h3FD, 10'd100};
    bus.din = '0; bus.vin = 1'b0; bus.rdy_in = 1'b0; bus.clr_ovf = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Three samples with the sink stalled: head must sit at 5.
    for (int i = 0; i < 3; i++) begin
      bus.vin = 1'b1; bus.din = v1[i];
      step();
    end
    bus.vin = 1'b0;
    step();
    check("dir_count3", 32'(bus.count), 32'd3);
    check("dir_head5",  32'(bus.dout),  32'd5);

    bus.rdy_in = 1'b1;
    repeat (3) step();
    bus.rdy_in = 1'b0;
    check("dir_empty", 32'(bus.empty), 32'd1);
    check("dir_dout0", 32'(bus.dout),  32'd0);

    // Ten writes into eight entries: last two are dropped.
    for (int i = 1; i <= 10; i++) begin
      bus.vin = 1'b1; bus.din = NB'(i);
      step();
    end
    check("ovf_full", 32'(bus.full),  32'd1);
    check("ovf_set",  32'(bus.ovf),   32'd1);
    check("ovf_head", 32'(bus.dout),  32'd1);

    // Full with concurrent read and write: count pinned at DEPTH.
    bus.rdy_in = 1'b1;
    for (int i = 20; i < 24; i++) begin
      bus.din = NB'(i);
      step();
    end
    check("rw_full_count", 32'(bus.count), 32'(DEPTH));
    check("rw_full_ovf",   32'(bus.ovf),   32'd1);
    bus.vin = 1'b0;
    repeat (DEPTH) step();
    bus.rdy_in = 1'b0;
    check("drain_empty", 32'(bus.empty), 32'd1);

    // Refill, then clear together with an overflowing write.
    for (int i = 0; i < DEPTH; i++) begin
      bus.vin = 1'b1; bus.din = NB'(40 + i);
      step();
    end
    bus.din = 10'd99; bus.clr_ovf = 1'b1;
    step();
    check("clr_vs_set", 32'(bus.ovf), 32'd1);
    bus.vin = 1'b0;
    step();
    bus.clr_ovf = 1'b0;
    check("clr_alone", 32'(bus.ovf), 32'd0);

    // Down to five entries with wrapped pointers, then async reset mid-cycle.
    bus.rdy_in = 1'b1;
    repeat (3) step();
    bus.rdy_in = 1'b0;
    check("pre_rst_count", 32'(bus.count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_vout",  32'(bus.vout),  32'd0);
    check("mid_rst_dout",  32'(bus.dout),  32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.vin = 1'b1; bus.din = 10'd7;
    step();
    bus.vin = 1'b0;
    check("post_rst_dout",  32'(bus.dout),  32'd7);
    check("post_rst_count", 32'(bus.count), 32'd1);

    // Randomised traffic with bursty sink stalls.
    for (int i = 0; i < 600; i++) begin
      bus.vin     = ($urandom_range(0, 99) < 60);
      bus.din     = NB'($urandom);
      if ($urandom_range(0, 99) < 20) bus.rdy_in = ~bus.rdy_in;
      bus.clr_ovf = ($urandom_range(0, 99) < 5);
      step();
    end
    bus.vin = 1'b0; bus.clr_ovf = 1'b0; bus.rdy_in = 1'b1;
    repeat (DEPTH + 2) step();
    check("final_empty", 32'(bus.empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
